// File: rtl/dequant_sequencer.sv
// Dequantize sequencer: holds per-lane scales, feeds accumulator rows through a
// two-stage register pipeline around an external datapath, and tracks job progress.
module dequant_sequencer #(
    parameter int unsigned LANES_NUM = 16,
    parameter int unsigned FP_DATA_W = 32,
    parameter int unsigned FP_MANT_W = 23,
    parameter int unsigned FP_EXP_W  = 8,
    parameter int unsigned ROWS_W    = 16
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           start_i,
    input  logic [ROWS_W-1:0]              num_rows_i,
    input  logic                           scale_wr_i,
    input  logic [LANES_NUM*FP_MANT_W-1:0] scale_mant_i,
    input  logic [LANES_NUM*FP_EXP_W-1:0]  scale_exp_i,
    input  logic                           acc_valid_i,
    output logic                           acc_ready_o,
    input  logic [LANES_NUM*FP_DATA_W-1:0] acc_data_i,
    output logic [LANES_NUM*FP_DATA_W-1:0] deq_q_data_o,
    output logic [LANES_NUM*FP_MANT_W-1:0] deq_mant_o,
    output logic [LANES_NUM*FP_EXP_W-1:0]  deq_exp_o,
    input  logic [LANES_NUM*FP_DATA_W-1:0] deq_r_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [LANES_NUM*FP_DATA_W-1:0] out_data_o,
    output logic                           out_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                         state;
    logic [ROWS_W-1:0]              num_rows;
    logic [ROWS_W-1:0]              acc_cnt;
    logic [LANES_NUM*FP_MANT_W-1:0] mant_q;
    logic [LANES_NUM*FP_EXP_W-1:0]  exp_q;
    logic                           v1;
    logic                           last1;
    logic                           advance;
    logic                           in_hs;
    logic                           out_hs;
    logic                           final_row;

    assign advance     = !out_valid_o || out_ready_i;
    assign acc_ready_o = (state == RUN) && (acc_cnt < num_rows) && (!v1 || advance);
    assign in_hs       = acc_valid_i && acc_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;
    // num_rows >= 1 whenever RUN is reachable, so the subtraction never wraps.
    assign final_row   = (acc_cnt == num_rows - ROWS_W'(1));

    assign deq_mant_o  = mant_q;
    assign deq_exp_o   = exp_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            num_rows <= '0;
            acc_cnt  <= '0;
            mant_q   <= '0;
            exp_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scale_wr_i) begin
                        mant_q <= scale_mant_i;
                        exp_q  <= scale_exp_i;
                    end
                    if (start_i) begin
                        num_rows <= num_rows_i;
                        acc_cnt  <= '0;
                        busy_o   <= 1'b1;
                        if (num_rows_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        acc_cnt <= acc_cnt + ROWS_W'(1);
                        if (final_row) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_hs && out_last_o) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S1 captures the accepted row with its last-row tag; S2 captures the datapath result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1           <= 1'b0;
            last1        <= 1'b0;
            deq_q_data_o <= '0;
            out_valid_o  <= 1'b0;
            out_last_o   <= 1'b0;
            out_data_o   <= '0;
        end else begin
            if (in_hs) begin
                v1           <= 1'b1;
                last1        <= final_row;
                deq_q_data_o <= acc_data_i;
            end else if (advance) begin
                v1 <= 1'b0;
            end
            if (advance) begin
                out_data_o  <= deq_r_data_i;
                out_valid_o <= v1;
                out_last_o  <= v1 && last1;
            end
        end
    end

endmodule

// File: tb/tb_dequant_sequencer.sv
// Scoreboard bench for dequant_sequencer with a behavioural dequantize datapath
// (acc * (1.mant) * 2^(exp-127), truncated to FP32) closing the loop.
module tb_dequant_sequencer;

    localparam int L  = 16;
    localparam int DW = L * 32;
    localparam int MW = L * 23;
    localparam int EW = L * 8;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   num_rows_i = '0;
    logic          scale_wr_i = 1'b0;
    logic [MW-1:0] scale_mant_i = '0;
    logic [EW-1:0] scale_exp_i = '0;
    logic          acc_valid_i = 1'b0;
    logic          acc_ready_o;
    logic [DW-1:0] acc_data_i = '0;
    logic [DW-1:0] deq_q_data_o;
    logic [MW-1:0] deq_mant_o;
    logic [EW-1:0] deq_exp_o;
    logic [DW-1:0] deq_r_data_i;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;

    dequant_sequencer #(
        .LANES_NUM(L), .FP_DATA_W(32), .FP_MANT_W(23), .FP_EXP_W(8), .ROWS_W(16)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .num_rows_i(num_rows_i),
        .scale_wr_i(scale_wr_i), .scale_mant_i(scale_mant_i), .scale_exp_i(scale_exp_i),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_data_i(acc_data_i),
        .deq_q_data_o(deq_q_data_o), .deq_mant_o(deq_mant_o), .deq_exp_o(deq_exp_o),
        .deq_r_data_i(deq_r_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [22:0] tb_mant [L];
    logic [7:0]  tb_exp  [L];

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        int            hs_cyc;
        bit            lat;
    } ent_t;
    ent_t sb[$];

    // Behavioural datapath: real arithmetic, then double -> FP32 by truncation.
    function automatic logic [31:0] ref_lane(logic [31:0] q, logic [22:0] m, logic [7:0] e);
        real         r;
        int          sq;
        logic [63:0] b;
        logic [10:0] be;
        sq = $signed(q);
        r  = $itor(sq) * (1.0 + $itor(m) / 8388608.0);
        if (e >= 8'd127) for (int i = 0; i < int'(e) - 127; i++) r = r * 2.0;
        else             for (int i = 0; i < 127 - int'(e); i++) r = r / 2.0;
        if (r == 0.0) return 32'h0;
        b  = $realtobits(r);
        be = b[62:52] - 11'd896;
        return {b[63], be[7:0], b[51:29]};
    endfunction

    always_comb begin
        deq_r_data_i = '0;
        for (int l = 0; l < L; l++)
            deq_r_data_i[l*32 +: 32] = ref_lane(deq_q_data_o[l*32 +: 32],
                                                deq_mant_o[l*23 +: 23], deq_exp_o[l*8 +: 8]);
    end

    // Expected value built with integer arithmetic, independent of the datapath model.
    function automatic logic [31:0] exp_lane(int v, logic [22:0] m, logic [7:0] e);
        logic [63:0] mag, p, fr;
        int          msb, ex;
        logic [7:0]  ex8;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 64'(-longint'(v)) : 64'(v);
        p   = mag * (64'd8388608 + 64'(m));
        msb = 0;
        for (int i = 0; i < 64; i++) if (p[i]) msb = i;
        fr  = p >> (msb - 23);
        ex  = msb - 23 + int'(e);
        ex8 = ex[7:0];
        return {v < 0, ex8, fr[22:0]};
    endfunction

    function automatic logic [DW-1:0] mk_row(int r);
        logic [DW-1:0] d;
        int v;
        for (int l = 0; l < L; l++) begin
            v = r * 16 + l + 1;
            if (l % 2 == 1) v = -v;
            d[l*32 +: 32] = v;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] exp_row(logic [DW-1:0] d);
        logic [DW-1:0] e;
        for (int l = 0; l < L; l++)
            e[l*32 +: 32] = exp_lane($signed(d[l*32 +: 32]), tb_mant[l], tb_exp[l]);
        return e;
    endfunction

    function automatic logic [MW-1:0] pack_mant();
        logic [MW-1:0] p;
        for (int l = 0; l < L; l++) p[l*23 +: 23] = tb_mant[l];
        return p;
    endfunction

    function automatic logic [EW-1:0] pack_exp();
        logic [EW-1:0] p;
        for (int l = 0; l < L; l++) p[l*8 +: 8] = tb_exp[l];
        return p;
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks stall stability.
    ent_t          mon_e;
    bit            stall_prev = 0;
    logic [DW-1:0] stall_d;
    logic          stall_l;
    int            last_out_cyc = 0;

    always @(negedge clk) begin
        if (rstn_i) begin
            if (stall_prev) begin
                n_tests++;
                if (!out_valid_o || out_data_o !== stall_d || out_last_o !== stall_l) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b last=%0b expected last=%0b data changed=%0b",
                             out_valid_o, out_last_o, stall_l, out_data_o !== stall_d);
                end
            end
            if (out_valid_o && out_ready_i) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_row: got %h expected no row", out_data_o);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_data_o !== mon_e.d || out_last_o !== mon_e.last) begin
                        n_fail++;
                        $display("FAIL row: got %h last=%0b expected %h last=%0b",
                                 out_data_o, out_last_o, mon_e.d, mon_e.last);
                    end
                    if (mon_e.lat) begin
                        n_tests++;
                        if (cyc - mon_e.hs_cyc != 2) begin
                            n_fail++;
                            $display("FAIL latency: got %0d expected 2", cyc - mon_e.hs_cyc);
                        end
                    end
                end
                last_out_cyc = cyc;
            end
            stall_prev = out_valid_o && !out_ready_i;
            stall_d    = out_data_o;
            stall_l    = out_last_o;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic load_scale();
        scale_mant_i = pack_mant();
        scale_exp_i  = pack_exp();
        scale_wr_i   = 1'b1;
        @(posedge clk); #1;
        scale_wr_i   = 1'b0;
    endtask

    task automatic start_job(int n);
        start_i    = 1'b1;
        num_rows_i = 16'(n);
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic send_row(logic [DW-1:0] d, logic [DW-1:0] e, bit last, bit lat);
        bit ok = 0;
        acc_valid_i = 1'b1;
        acc_data_i  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc_ready_o) begin ok = 1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL acc_handshake: got no acc_ready_o expected ready within 200 cycles");
        end else begin
            sb.push_back('{d: e, last: last, hs_cyc: cyc, lat: lat});
        end
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
    endtask

    task automatic wait_done(bit chk_gap);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL done_timeout: got no done_o expected pulse within 200 cycles");
        end else if (chk_gap) begin
            chk("done_gap", DW'(cyc - last_out_cyc), DW'(1));
        end
        @(negedge clk);
        chk("done_pulse_end", DW'(done_o), DW'(0));
        chk("busy_end", DW'(busy_o), DW'(0));
        chk("sb_empty", DW'(sb.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", DW'(busy_o), DW'(0));
        chk("rst_valid", DW'(out_valid_o), DW'(0));
        chk("rst_ready", DW'(acc_ready_o), DW'(0));
        chk("rst_mant", DW'(deq_mant_o), DW'(0));
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // Four-row job, no backpressure: latency 2, back-to-back rows, last on row 3.
        for (int l = 0; l < L; l++) begin tb_mant[l] = '0; tb_exp[l] = 8'(126 + l % 3); end
        load_scale();
        @(negedge clk);
        chk("scale_mant", DW'(deq_mant_o), DW'(pack_mant()));
        chk("scale_exp", DW'(deq_exp_o), DW'(pack_exp()));
        @(posedge clk); #1;
        start_job(4);
        for (int r = 0; r < 4; r++) send_row(mk_row(r), exp_row(mk_row(r)), r == 3, 1);
        wait_done(1);

        // Zero-row job: one busy/done cycle and nothing else.
        start_job(0);
        @(negedge clk);
        chk("z_busy", DW'(busy_o), DW'(1));
        chk("z_done", DW'(done_o), DW'(1));
        chk("z_ready", DW'(acc_ready_o), DW'(0));
        chk("z_valid", DW'(out_valid_o), DW'(0));
        @(negedge clk);
        chk("z_busy2", DW'(busy_o), DW'(0));
        chk("z_done2", DW'(done_o), DW'(0));
        @(posedge clk); #1;

        // Backpressure: two rows fill the pipe, the third waits until the sink drains.
        out_ready_i = 1'b0;
        start_job(3);
        send_row(mk_row(10), exp_row(mk_row(10)), 0, 0);
        send_row(mk_row(11), exp_row(mk_row(11)), 0, 0);
        @(negedge clk);
        chk("bp_ready_low", DW'(acc_ready_o), DW'(0));
        chk("bp_valid", DW'(out_valid_o), DW'(1));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send_row(mk_row(12), exp_row(mk_row(12)), 1, 0);
        wait_done(0);

        // Scale write and start mid-job must be ignored.
        for (int l = 0; l < L; l++) begin tb_mant[l] = 23'(l << 18); tb_exp[l] = 8'(126 + l % 4); end
        load_scale();
        start_job(3);
        send_row(mk_row(20), exp_row(mk_row(20)), 0, 0);
        scale_mant_i = '1;
        scale_exp_i  = {L{8'd200}};
        scale_wr_i   = 1'b1;
        start_i      = 1'b1;
        num_rows_i   = 16'd10;
        @(posedge clk); #1;
        scale_wr_i   = 1'b0;
        start_i      = 1'b0;
        @(negedge clk);
        chk("mid_mant", DW'(deq_mant_o), DW'(pack_mant()));
        chk("mid_exp", DW'(deq_exp_o), DW'(pack_exp()));
        @(posedge clk); #1;
        send_row(mk_row(21), exp_row(mk_row(21)), 0, 0);
        send_row(mk_row(22), exp_row(mk_row(22)), 1, 0);
        wait_done(0);

        // Reset with two rows in flight, then a fresh job.
        out_ready_i = 1'b0;
        start_job(4);
        send_row(mk_row(30), exp_row(mk_row(30)), 0, 0);
        send_row(mk_row(31), exp_row(mk_row(31)), 0, 0);
        rstn_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mr_valid", DW'(out_valid_o), DW'(0));
        chk("mr_last", DW'(out_last_o), DW'(0));
        chk("mr_busy", DW'(busy_o), DW'(0));
        chk("mr_ready", DW'(acc_ready_o), DW'(0));
        chk("mr_qdata", deq_q_data_o, DW'(0));
        chk("mr_odata", out_data_o, DW'(0));
        chk("mr_exp", DW'(deq_exp_o), DW'(0));
        @(posedge clk); #1;
        rstn_i = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("mr_idle_busy", DW'(busy_o), DW'(0));
        @(posedge clk); #1;
        for (int l = 0; l < L; l++) begin tb_mant[l] = '0; tb_exp[l] = 8'(126 + l % 3); end
        load_scale();
        start_job(2);
        send_row(mk_row(40), exp_row(mk_row(40)), 0, 1);
        send_row(mk_row(41), exp_row(mk_row(41)), 1, 1);
        wait_done(1);

        // Lane l scaled by 2^-l on 256: FP32 exponent field 135-l, zero mantissa.
        begin
            logic [DW-1:0] d, e;
            for (int l = 0; l < L; l++) begin
                tb_mant[l] = '0;
                tb_exp[l]  = 8'(127 - l);
                d[l*32 +: 32] = 32'd256;
                e[l*32 +: 32] = {1'b0, 8'(135 - l), 23'd0};
            end
            load_scale();
            start_job(1);
            send_row(d, e, 1, 1);
            wait_done(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
